imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed little-endian byte image into
// instruction memory and holds the core in reset until the image is complete.
// Optional trailing checksum word: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rstn,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int          WIDX_W = ADDR_WIDTH + 1;
  localparam logic [31:0] CAP    = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM  = 3'd3,
`endif
    S_FLUSH = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  // Where the stream goes once all data words have arrived.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e POST_DATA = S_CSUM;
`else
  localparam state_e POST_DATA = S_FLUSH;
`endif

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [1:0]          bpos_q, bpos_d;
  logic [23:0]         asm_q, asm_d;
  logic                we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                crst_q, crst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;
`endif

  logic                accept_s;
  logic                word_done_s;
  logic                asm_state_s;
  logic                last_s;
  logic [15:0]         n_s;
  logic [31:0]         word_s;

  assign accept_s = rx_valid && rx_ready;
  assign n_s      = {rx_data, len_q[7:0]};
  assign word_s   = {rx_data, asm_q};
  assign last_s   = ((32'(widx_q) + 32'd1) == 32'(len_q));

  // Ready is a pure state decode so the sender sees it without a cycle of lag.
  always_comb begin
    case (state_q)
      S_LEN0, S_LEN1, S_DATA: rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                 rx_ready = 1'b1;
`endif
      default:                rx_ready = 1'b0;
    endcase
  end

  // Word assembly plus next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    widx_d      = widx_q;
    bpos_d      = bpos_q;
    asm_d       = asm_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word_done_s = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    asm_state_s = (state_q == S_DATA) || (state_q == S_CSUM);
`else
    asm_state_s = (state_q == S_DATA);
`endif

    // Bytes fill the low three lanes; the fourth byte completes the word
    // directly from rx_data, and the position wraps back to 0.
    if (accept_s && asm_state_s) begin
      bpos_d = bpos_q + 2'd1;
      case (bpos_q)
        2'd0:    asm_d[7:0]   = rx_data;
        2'd1:    asm_d[15:8]  = rx_data;
        2'd2:    asm_d[23:16] = rx_data;
        default: word_done_s  = 1'b1;
      endcase
    end else begin
      bpos_d = bpos_q;
    end

    case (state_q)
      S_LEN0: begin
        if (accept_s) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end else begin
          state_d = S_LEN0;
        end
      end
      S_LEN1: begin
        if (accept_s) begin
          len_d  = n_s;
          widx_d = '0;
          bpos_d = 2'd0;
          if (32'(n_s) > CAP) begin
            state_d = S_ERR;
          end else if (n_s == 16'd0) begin
            state_d = POST_DATA;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_LEN1;
        end
      end
      S_DATA: begin
        if (word_done_s) begin
          we_d    = 1'b1;
          addr_d  = widx_q[ADDR_WIDTH-1:0];
          wdata_d = word_s;
          widx_d  = widx_q + WIDX_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q + word_s;
`endif
          if (last_s) begin
            state_d = POST_DATA;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (word_done_s) begin
          if (word_s == csum_q) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
`endif
      S_FLUSH: state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    // Release lags RUN entry by one edge so the last write settles first.
    crst_d = (state_q == S_RUN);
    done_d = (state_q == S_RUN);
    err_d  = (state_d == S_ERR);
  end

  // State and output registers; reset asynchronously forces the core back into reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_LEN0;
      len_q   <= 16'd0;
      widx_q  <= '0;
      bpos_q  <= 2'd0;
      asm_q   <= 24'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      crst_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      bpos_q  <= bpos_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rstn  = crst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios, hand-written
// timing/reset sequences, and random images against a stream-level model.
module tb_imem_loader;

  localparam int AW  = 8;
  localparam int CAP = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rstn;
  logic          load_done;
  logic          load_err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rstn  (core_rstn),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
    logic        crst;
  } wr_t;

  wr_t  wq[$];
  int   rise_q[$];
  logic cr_prev = 1'b0;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // capture imem writes and core release edges, away from the active edge
  always @(negedge clk) begin
    if (imem_we) wq.push_back('{int'(imem_addr), imem_wdata, cyc, core_rstn});
    if (core_rstn && !cr_prev) rise_q.push_back(cyc);
    cr_prev <= core_rstn;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("rst_rx_ready",  32'(rx_ready),  32'd1);
    chk("rst_imem_we",   32'(imem_we),   32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata",     imem_wdata,     32'd0);
    chk("rst_core_rstn", 32'(core_rstn), 32'd0);
    chk("rst_done",      32'(load_done), 32'd0);
    chk("rst_err",       32'(load_err),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // thr: 0 = valid every cycle, 1 = valid every other cycle, 2 = random gaps
  task automatic send(input logic [7:0] s[$], input int thr, output bit to);
    int idx = 0;
    int spent = 0;
    bit ph = 1'b0;
    bit v;
    to = 1'b0;
    while (idx < s.size()) begin
      @(negedge clk);
      if (!rx_ready) begin
        rx_valid = 1'b0;
        break;
      end
      case (thr)
        0:       v = 1'b1;
        1:       v = ph;
        default: v = 1'($urandom_range(0, 1));
      endcase
      ph = ~ph;
      rx_valid = v;
      rx_data = v ? s[idx] : 8'($urandom);
      @(posedge clk);
      if (v) idx++;
      spent++;
      if (spent > 20000) begin
        to = 1'b1;
        break;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // Stream-level reference: parse the byte image the way a host would.
  task automatic model(input logic [7:0] s[$], output int ea[$], output logic [31:0] ed[$],
                       output bit done, output bit err);
    int n;
    logic [31:0] sum, w;
    ea = {};
    ed = {};
    done = 1'b0;
    err = 1'b0;
    sum = 32'd0;
    n = int'(s[0]) + 256 * int'(s[1]);
    if (n > CAP) begin
      err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
      ea.push_back(i);
      ed.push_back(w);
      sum = sum + w;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    w = {s[2+4*n+3], s[2+4*n+2], s[2+4*n+1], s[2+4*n]};
    if (w == sum) done = 1'b1;
    else err = 1'b1;
`else
    done = 1'b1;
`endif
  endtask

  // pat: 0 = word equals index, 1 = random, 2 = 0x11111111*(index+1)
  task automatic build(input int n, input int pat, input bit bad, output logic [7:0] s[$]);
    logic [31:0] w, sum;
    s = {};
    sum = 32'd0;
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    if (n > CAP) begin
      for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
      return;
    end
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       w = 32'(i);
        1:       w = $urandom;
        default: w = 32'h11111111 * 32'(i + 1);
      endcase
      sum = sum + w;
      for (int b = 0; b < 4; b++) s.push_back(8'(w >> (8 * b)));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (bad) sum = sum + 32'd1;
    for (int b = 0; b < 4; b++) s.push_back(8'(sum >> (8 * b)));
`endif
  endtask

  task automatic run_case(input logic [7:0] s[$], input int thr, input bit rst,
                          output int nwr, output bit d_o, output bit e_o);
    int base, m;
    int ea[$];
    logic [31:0] ed[$];
    bit edone, eerr, to;
    if (rst) do_reset();
    base = wq.size();
    send(s, thr, to);
    chk("send_timeout", 32'(to), 32'd0);
    repeat (6) @(negedge clk);
    model(s, ea, ed, edone, eerr);
    nwr = wq.size() - base;
    chk("wr_count", 32'(nwr), 32'(ea.size()));
    m = (nwr < ea.size()) ? nwr : ea.size();
    for (int i = 0; i < m; i++) begin
      chk("wr_addr", 32'(wq[base+i].addr), 32'(ea[i]));
      chk("wr_data", wq[base+i].data, ed[i]);
      chk("wr_core_held", 32'(wq[base+i].crst), 32'd0);
    end
    chk("load_done",    32'(load_done), 32'(edone));
    chk("load_err",     32'(load_err),  32'(eerr));
    chk("core_rstn",    32'(core_rstn), 32'(edone));
    chk("rx_ready_end", 32'(rx_ready),  32'd0);
    d_o = load_done;
    e_o = load_err;
  endtask

  typedef struct {
    int n;
    int pat;
    int thr;
    bit bad;
    bit exp_done;
    bit exp_err;
    int exp_nwr;
  } vec_t;

  initial begin
    vec_t vt[$];
    logic [7:0] s[$];
    int nwr, bw, br;
    bit d, e;

    vt.push_back('{2,     0, 0, 1'b0, 1'b1, 1'b0, 2});
    vt.push_back('{2,     0, 1, 1'b0, 1'b1, 1'b0, 2});
    vt.push_back('{257,   1, 0, 1'b0, 1'b0, 1'b1, 0});
    vt.push_back('{256,   0, 0, 1'b0, 1'b1, 1'b0, 256});
    vt.push_back('{0,     1, 0, 1'b0, 1'b1, 1'b0, 0});
    vt.push_back('{1,     1, 2, 1'b0, 1'b1, 1'b0, 1});
    vt.push_back('{5,     1, 2, 1'b0, 1'b1, 1'b0, 5});
    vt.push_back('{65535, 1, 0, 1'b0, 1'b0, 1'b1, 0});
`ifdef IMEM_LOADER_CHECKSUM_EN
    vt.push_back('{2,     2, 0, 1'b0, 1'b1, 1'b0, 2});
    vt.push_back('{2,     2, 0, 1'b1, 1'b0, 1'b1, 2});
`endif

    for (int k = 0; k < vt.size(); k++) begin
      build(vt[k].n, vt[k].pat, vt[k].bad, s);
      run_case(s, vt[k].thr, 1'b1, nwr, d, e);
      chk("tbl_done", 32'(d),   32'(vt[k].exp_done));
      chk("tbl_err",  32'(e),   32'(vt[k].exp_err));
      chk("tbl_nwr",  32'(nwr), 32'(vt[k].exp_nwr));
    end

    // Nominal image: exact write values, 4-cycle pulse spacing, release latency.
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'h82); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00);
`endif
    bw = wq.size();
    br = rise_q.size();
    run_case(s, 0, 1'b1, nwr, d, e);
    chk("nom_rise_count", 32'(rise_q.size() - br), 32'd1);
    if (nwr >= 2 && rise_q.size() > br) begin
      chk("nom_w0", wq[bw].data, 32'h00000013);
      chk("nom_w1", wq[bw+1].data, 32'h0000006F);
      chk("nom_spacing", 32'(wq[bw+1].cyc - wq[bw].cyc), 32'd4);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("nom_release", 32'(rise_q[br] - wq[bw+1].cyc), 32'd6);
`else
      chk("nom_release", 32'(rise_q[br] - wq[bw+1].cyc), 32'd2);
`endif
    end

    // Reset in the middle of a word, then a fresh load without another reset.
    do_reset();
    s = '{8'h02, 8'h00, 8'h13, 8'h00};
    send(s, 0, d);
    chk("mid_send_timeout", 32'(d), 32'd0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_core_rstn", 32'(core_rstn), 32'd0);
    chk("mid_done",      32'(load_done), 32'd0);
    chk("mid_we",        32'(imem_we),   32'd0);
    @(negedge clk);
    rstn = 1'b1;
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'hAA); s.push_back(8'hBB); s.push_back(8'hCC); s.push_back(8'hDD);
`endif
    bw = wq.size();
    run_case(s, 0, 1'b0, nwr, d, e);
    if (nwr >= 1) begin
      chk("mid_w0_addr", 32'(wq[bw].addr), 32'd0);
      chk("mid_w0_data", wq[bw].data, 32'hDDCCBBAA);
    end

    // Asynchronous reset while the core is running drops core_rstn before any edge.
    chk("run_core_rstn", 32'(core_rstn), 32'd1);
    @(negedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("async_core_rstn", 32'(core_rstn), 32'd0);
    chk("async_done",      32'(load_done), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Random images against the stream model.
    for (int r = 0; r < 15; r++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? 257 + int'($urandom_range(0, 3))
                                      : int'($urandom_range(0, 40));
      build(n, 1, 1'($urandom_range(0, 3) == 0), s);
      run_case(s, int'($urandom_range(0, 2)), 1'b1, nwr, d, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
